// File: rtl/sync_multi.sv
// Multi-channel Gray-pointer synchroniser: STAGES-deep sync chain per channel, registered binary view and update pulse.
// Define SYNC_GRAY_CHECK_EN to build the per-channel illegal-hop checker driving err_trg.
module sync_multi #(
    parameter int ADDR_WIDTH = 8,
    parameter int STAGES     = 2,
    parameter int CHANNELS   = 1
) (
    input  logic                           clk_trg,
    input  logic                           rst_trg,
    input  logic [CHANNELS*ADDR_WIDTH-1:0] addr_src,
    input  logic [CHANNELS-1:0]            err_clr,
    output logic [CHANNELS*ADDR_WIDTH-1:0] addr_trg,
    output logic [CHANNELS*ADDR_WIDTH-1:0] addr_bin_trg,
    output logic [CHANNELS-1:0]            upd_trg,
    output logic [CHANNELS-1:0]            err_trg
);

    generate
        if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
            $error("sync_multi: STAGES must be in 2..4");
        end
        if (ADDR_WIDTH < 2 || ADDR_WIDTH > 32) begin : g_bad_width
            $error("sync_multi: ADDR_WIDTH must be in 2..32");
        end
        if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
            $error("sync_multi: CHANNELS must be in 1..8");
        end
    endgenerate

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [ADDR_WIDTH-1:0] stage_q [STAGES];
        logic [ADDR_WIDTH-1:0] prev_q;
        logic [ADDR_WIDTH-1:0] bin_q;
        logic                  upd_q;
        logic [ADDR_WIDTH-1:0] gray;
        logic [ADDR_WIDTH-1:0] bin_d;
        logic [ADDR_WIDTH-1:0] diff;

        always_ff @(posedge clk_trg or posedge rst_trg) begin
            if (rst_trg) begin
                for (int i = 0; i < STAGES; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_q[0] <= addr_src[c*ADDR_WIDTH +: ADDR_WIDTH];
                for (int i = 1; i < STAGES; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign gray = stage_q[STAGES-1];
        assign diff = gray ^ prev_q;

        // Each binary bit is the XOR of all Gray bits at or above it.
        always_comb begin
            bin_d = '0;
            for (int i = 0; i < ADDR_WIDTH; i++) begin
                bin_d[i] = ^(gray >> i);
            end
        end

        always_ff @(posedge clk_trg or posedge rst_trg) begin
            if (rst_trg) begin
                prev_q <= '0;
                bin_q  <= '0;
                upd_q  <= 1'b0;
            end else begin
                prev_q <= gray;
                bin_q  <= bin_d;
                upd_q  <= (diff != '0);
            end
        end

`ifdef SYNC_GRAY_CHECK_EN
        logic illegal;
        logic err_q;

        // More than one set bit in diff: clearing the lowest set bit leaves something behind.
        assign illegal = ((diff & (diff - 1'b1)) != '0);

        always_ff @(posedge clk_trg or posedge rst_trg) begin
            if (rst_trg) begin
                err_q <= 1'b0;
            end else if (illegal) begin
                err_q <= 1'b1;
            end else if (err_clr[c]) begin
                err_q <= 1'b0;
            end
        end

        assign err_trg[c] = err_q;
`else
        assign err_trg[c] = 1'b0;
`endif

        assign addr_trg[c*ADDR_WIDTH +: ADDR_WIDTH]     = gray;
        assign addr_bin_trg[c*ADDR_WIDTH +: ADDR_WIDTH] = bin_q;
        assign upd_trg[c]                               = upd_q;
    end

`ifndef SYNC_GRAY_CHECK_EN
    logic unused_err_clr;
    assign unused_err_clr = ^err_clr;
`endif

endmodule

// File: tb/tb_sync_multi.sv
// Scoreboard bench for sync_multi: a queue-based reference model predicts each update pulse, a monitor pops on upd_trg.
// Error expectations follow SYNC_GRAY_CHECK_EN as seen by this compilation.
module tb_sync_multi;

    localparam int AW = 8;
    localparam int ST = 3;
    localparam int CH = 4;
    localparam int W  = CH * AW;
`ifdef SYNC_GRAY_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic          clk_trg = 1'b0;
    logic          rst_trg;
    logic [W-1:0]  addr_src;
    logic [CH-1:0] err_clr;
    logic [W-1:0]  addr_trg;
    logic [W-1:0]  addr_bin_trg;
    logic [CH-1:0] upd_trg;
    logic [CH-1:0] err_trg;

    sync_multi #(.ADDR_WIDTH(AW), .STAGES(ST), .CHANNELS(CH)) dut (
        .clk_trg      (clk_trg),
        .rst_trg      (rst_trg),
        .addr_src     (addr_src),
        .err_clr      (err_clr),
        .addr_trg     (addr_trg),
        .addr_bin_trg (addr_bin_trg),
        .upd_trg      (upd_trg),
        .err_trg      (err_trg)
    );

    always #5 clk_trg = ~clk_trg;

    typedef struct {
        int            cyc;
        logic [AW-1:0] bin;
    } evt_t;

    evt_t          evq      [CH][$];
    logic [AW-1:0] pipe     [CH][$];
    logic [AW-1:0] exp_trg  [CH];
    logic [AW-1:0] exp_last [CH];
    logic          exp_err  [CH];
    int            pulse_cnt[CH];
    int            snap     [CH];
    int            cyc;
    int            checks;
    int            failures;
    logic [W-1:0]  v;

    function automatic logic [AW-1:0] gray2bin(input logic [AW-1:0] g);
        logic [AW-1:0] b;
        b = g;
        for (int s = 1; s < AW; s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic logic [AW-1:0] bin2gray(input logic [AW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [W-1:0] randSrc();
        logic [W-1:0] r;
        for (int c = 0; c < CH; c++) r[c*AW +: AW] = AW'($urandom);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A sample taken on an edge becomes visible ST-1 edges later, hence ST-1 zeros preloaded.
    task automatic modelReset();
        for (int c = 0; c < CH; c++) begin
            pipe[c].delete();
            for (int i = 0; i < ST - 1; i++) pipe[c].push_back('0);
            exp_trg[c]  = '0;
            exp_last[c] = '0;
            exp_err[c]  = 1'b0;
            evq[c].delete();
        end
    endtask

    task automatic modelEdge();
        for (int c = 0; c < CH; c++) begin
            logic [AW-1:0] d;
            evt_t          ev;
            d = exp_trg[c] ^ exp_last[c];
            if (CHECK_EN && $countones(d) > 1) exp_err[c] = 1'b1;
            else if (CHECK_EN && err_clr[c])    exp_err[c] = 1'b0;
            if (d != '0) begin
                ev.cyc = cyc;
                ev.bin = gray2bin(exp_trg[c]);
                evq[c].push_back(ev);
            end
            exp_last[c] = exp_trg[c];
            pipe[c].push_back(addr_src[c*AW +: AW]);
            exp_trg[c] = pipe[c].pop_front();
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] src, input logic [CH-1:0] clr);
        addr_src = src;
        err_clr  = clr;
        @(posedge clk_trg);
        cyc++;
        modelEdge();
        #1;
    endtask

    task automatic checkOutput();
        evt_t dump;
        for (int c = 0; c < CH; c++) begin
            check($sformatf("addr_trg[%0d]", c), 64'(addr_trg[c*AW +: AW]), 64'(exp_trg[c]));
            check($sformatf("err_trg[%0d]", c), 64'(err_trg[c]), 64'(exp_err[c]));
            if (upd_trg[c]) begin
                if (evq[c].size() == 0 || evq[c][0].cyc != cyc) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL upd_spurious[%0d] actual=1 expected=0 (cycle %0d)", c, cyc);
                end else begin
                    check($sformatf("addr_bin_trg[%0d]", c), 64'(addr_bin_trg[c*AW +: AW]), 64'(evq[c][0].bin));
                    dump = evq[c].pop_front();
                    pulse_cnt[c]++;
                end
            end else if (evq[c].size() != 0 && evq[c][0].cyc <= cyc) begin
                checks++;
                failures++;
                $display("[TB] FAIL upd_missing[%0d] actual=0 expected=1 (cycle %0d)", c, cyc);
                dump = evq[c].pop_front();
            end
        end
    endtask

    initial forever begin
        @(negedge clk_trg);
        if (rst_trg === 1'b0) checkOutput();
    end

    task automatic doReset();
        @(negedge clk_trg);
        #1;
        rst_trg = 1'b1;
        #1;
        check("rst_addr_trg", 64'(addr_trg), 64'd0);
        check("rst_addr_bin_trg", 64'(addr_bin_trg), 64'd0);
        check("rst_upd_trg", 64'(upd_trg), 64'd0);
        check("rst_err_trg", 64'(err_trg), 64'd0);
        modelReset();
        cyc = 0;
        @(posedge clk_trg);
        @(negedge clk_trg);
        #1;
        rst_trg = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        for (int c = 0; c < CH; c++) pulse_cnt[c] = 0;
        rst_trg  = 1'b1;
        addr_src = '0;
        err_clr  = '0;
        modelReset();
        repeat (2) @(posedge clk_trg);
        @(negedge clk_trg);
        #1;
        rst_trg = 1'b0;

        // Reset mid-stream with A5 on channel 0, then watch it re-emerge.
        repeat (10) applyStimulus(randSrc(), '0);
        v = randSrc();
        v[AW-1:0] = 8'hA5;
        repeat (5) applyStimulus(v, '0);
        doReset();
        for (int k = 1; k <= ST + 2; k++) begin
            applyStimulus(v, '0);
            if (k <= ST) check("no_upd_after_release", 64'(upd_trg), 64'd0);
            if (k == ST - 1) check("rst_lat_before", 64'(addr_trg[AW-1:0]), 64'h00);
            if (k == ST) check("rst_lat_a5", 64'(addr_trg[AW-1:0]), 64'hA5);
        end

        // Settle everything to zero and clear any sticky errors.
        repeat (ST + 3) applyStimulus('0, '1);
        repeat (2) applyStimulus('0, '0);
        check("err_cleared", 64'(err_trg), 64'd0);

        // Latency of a single-bit step on channel 0.
        v = '0;
        v[AW-1:0] = 8'h01;
        for (int k = 1; k <= ST + 2; k++) begin
            applyStimulus(v, '0);
            if (k == ST - 1) check("lat_trg_before", 64'(addr_trg[AW-1:0]), 64'h00);
            if (k == ST) begin
                check("lat_trg", 64'(addr_trg[AW-1:0]), 64'h01);
                check("lat_bin_before", 64'(addr_bin_trg[AW-1:0]), 64'h00);
            end
            if (k == ST + 1) begin
                check("lat_bin", 64'(addr_bin_trg[AW-1:0]), 64'h01);
                check("lat_upd", 64'(upd_trg), 64'b0001);
            end
            if (k == ST + 2) check("lat_upd_single", 64'(upd_trg), 64'd0);
        end

        // Full Gray count on channel 0 including the wrap back to zero.
        repeat (ST + 2) applyStimulus('0, '0);
        snap[0] = pulse_cnt[0];
        for (int i = 1; i <= (1 << AW); i++) begin
            logic [AW-1:0] b;
            b = i[AW-1:0];
            v = '0;
            v[AW-1:0] = bin2gray(b);
            repeat (2) applyStimulus(v, '0);
        end
        repeat (ST + 2) applyStimulus(v, '0);
        check("wrap_pulses", 64'(pulse_cnt[0] - snap[0]), 64'(1 << AW));
        check("wrap_err", 64'(err_trg[0]), 64'd0);
        check("wrap_bin_end", 64'(addr_bin_trg[AW-1:0]), 64'h00);

        // Illegal hop 00 -> 03, clear, then a hop that coincides with a clear.
        v = '0;
        v[AW-1:0] = 8'h03;
        repeat (ST + 1) applyStimulus(v, '0);
        check("hop_upd", 64'(upd_trg[0]), 64'd1);
        check("hop_err", 64'(err_trg[0]), 64'(CHECK_EN));
        check("hop_bin", 64'(addr_bin_trg[AW-1:0]), 64'h02);
        applyStimulus(v, 4'b0001);
        check("clr_err", 64'(err_trg[0]), 64'd0);
        for (int k = 1; k <= ST + 1; k++) begin
            applyStimulus('0, (k == ST + 1) ? 4'b0001 : 4'b0000);
        end
        check("set_wins_upd", 64'(upd_trg[0]), 64'd1);
        check("set_wins_err", 64'(err_trg[0]), 64'(CHECK_EN));
        repeat (2) applyStimulus('0, '0);
        applyStimulus('0, '1);

        // Only channel 2 moves, back-to-back legal steps.
        repeat (ST + 2) applyStimulus('0, '0);
        for (int c = 0; c < CH; c++) snap[c] = pulse_cnt[c];
        for (int n = 1; n <= 20; n++) begin
            logic [AW-1:0] b;
            b = n[AW-1:0];
            v = '0;
            v[2*AW +: AW] = bin2gray(b);
            applyStimulus(v, '0);
        end
        repeat (ST + 2) applyStimulus(v, '0);
        for (int c = 0; c < CH; c++) begin
            check($sformatf("indep_pulses[%0d]", c), 64'(pulse_cnt[c] - snap[c]), (c == 2) ? 64'd20 : 64'd0);
        end

        // Random traffic with occasional holds and random clears.
        for (int n = 0; n < 300; n++) begin
            logic [CH-1:0] clr;
            if ($urandom_range(0, 9) > 2) v = randSrc();
            for (int c = 0; c < CH; c++) clr[c] = ($urandom_range(0, 9) == 0);
            applyStimulus(v, clr);
        end
        repeat (ST + 3) applyStimulus(v, '0);

        for (int c = 0; c < CH; c++) begin
            check($sformatf("leftover_events[%0d]", c), 64'(evq[c].size()), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
